// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and request-field encodings for mem_mfc_ram.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic SZ_WORD  = 1'b1;
  localparam logic SZ_BYTE  = 1'b0;
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: 2^ADDR_W x 8 storage, 4-lane write, 32-bit little-endian read of lanes a..a+3.
module mem_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [7:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk_i)
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[addr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign rdata_o[8*g +: 8] = mem_q[addr_i + ADDR_W'(g)];
  end
endmodule

// File: rtl/mem_mfc_ram.sv
// mem_mfc_ram: byte-addressed RAM with MFA/MFC handshake and programmable wait states.
// MEM_ALIGN_FAULT_EN: misaligned word accesses are suppressed and flagged on FAULT.
module mem_mfc_ram
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        READ_WRITE,
  input  logic        WORD_BYTE,
  input  logic [31:0] MEMADD,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC,
  output logic        FAULT
);
  localparam int CNT_W = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, sz_q, misal, access;
  logic [31:0]       din_q, dout_q, rdata;
  logic [3:0]        we;
  logic              unused_addr;
  assign unused_addr = ^MEMADD[31:ADDR_W];
`ifdef MEM_ALIGN_FAULT_EN
  logic fault_q;
  assign addr_d = MEMADD[ADDR_W-1:0];
  assign misal  = sz_q == SZ_WORD && addr_q[1:0] != 2'b00;
  assign FAULT  = fault_q;
  // FAULT covers exactly the DONE cycles of a suppressed access
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) fault_q <= 1'b0;
    else if (access) fault_q <= misal;
    else if (state_q == DONE && !MFA) fault_q <= 1'b0;
`else
  assign addr_d = WORD_BYTE == SZ_WORD ? {MEMADD[ADDR_W-1:2], 2'b00} : MEMADD[ADDR_W-1:0];
  assign misal  = 1'b0;
  assign FAULT  = 1'b0;
`endif
  assign access   = state_q == WAIT && cnt_q == '0;
  assign we       = access && rw_q == RW_WRITE && !misal ? (sz_q == SZ_WORD ? 4'hF : 4'h1) : 4'h0;
  assign MFC      = state_q == DONE;
  assign DATA_OUT = dout_q;
  mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i  (Clk),
    .we_i   (we),
    .addr_i (addr_q),
    .wdata_i(din_q),
    .rdata_o(rdata)
  );
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      sz_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (MFA) begin
          addr_q  <= addr_d;
          rw_q    <= READ_WRITE;
          sz_q    <= WORD_BYTE;
          din_q   <= DATA_IN;
          cnt_q   <= CNT_W'(WAIT_CYCLES);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          state_q <= DONE;
          if (rw_q == RW_READ && !misal) dout_q <= sz_q == SZ_WORD ? rdata : {24'h0, rdata[7:0]};
        end
        DONE: if (!MFA) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_mfc_ram.sv
// tb_mem_mfc_ram: directed checks of handshake latency, data path, wrap and reset behaviour.
module tb_mem_mfc_ram;
  import mem_pkg::*;
  logic        Clk = 1'b0, Reset = 1'b0;
  logic        mfa = 1'b0, rw = 1'b0, wb = 1'b0, mfa0 = 1'b0, rw0 = 1'b0, wb0 = 1'b0;
  logic [31:0] addr = '0, din = '0, addr0 = '0, din0 = '0;
  logic [31:0] dout, dout0;
  logic        mfc, fault, mfc0, fault0;
  int          checks = 0, errors = 0;
  logic [7:0]  exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  always #5 Clk = ~Clk;
  mem_mfc_ram #(.ADDR_W(9), .WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .MFA(mfa), .READ_WRITE(rw), .WORD_BYTE(wb),
    .MEMADD(addr), .DATA_IN(din), .DATA_OUT(dout), .MFC(mfc), .FAULT(fault)
  );
  mem_mfc_ram #(.ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .MFA(mfa0), .READ_WRITE(rw0), .WORD_BYTE(wb0),
    .MEMADD(addr0), .DATA_IN(din0), .DATA_OUT(dout0), .MFC(mfc0), .FAULT(fault0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  // One full handshake; request inputs are scrambled after the latch edge to prove they are ignored
  task automatic xact(input bit s0, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int lat, input logic f);
    int n = 0;
    if (s0) begin mfa0 = 1'b1; rw0 = r; wb0 = w; addr0 = a; din0 = d; end
    else begin mfa = 1'b1; rw = r; wb = w; addr = a; din = d; end
    tick;
    if (s0) begin rw0 = ~r; wb0 = ~w; addr0 = ~a; din0 = ~d; end
    else begin rw = ~r; wb = ~w; addr = ~a; din = ~d; end
    while (!(s0 ? mfc0 : mfc) && n < 10) begin tick; n++; end
    chk("mfc_latency", 32'(n), 32'(lat));
    chk("fault_in_done", {31'h0, s0 ? fault0 : fault}, {31'h0, f});
    if (s0) mfa0 = 1'b0; else mfa = 1'b0;
    tick;
    chk("mfc_fall", {31'h0, s0 ? mfc0 : mfc}, 32'h0);
    chk("fault_after_done", {31'h0, s0 ? fault0 : fault}, 32'h0);
  endtask
  initial begin
    #2;
    chk("rst_mfc", {31'h0, mfc}, 32'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    #20 Reset = 1'b1;
    tick;
    xact(0, RW_WRITE, SZ_WORD, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    chk("write_keeps_dout", dout, 32'h0);
    xact(0, RW_READ, SZ_WORD, 32'h10, 32'h0, 3, 1'b0);
    chk("word_read_10", dout, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      xact(0, RW_READ, SZ_BYTE, 32'h10 + 32'(i), 32'h0, 3, 1'b0);
      chk("byte_read", dout, {24'h0, exp_b[i]});
    end
    mfa = 1'b1; rw = RW_WRITE; wb = SZ_WORD; addr = 32'h10; din = 32'hCAFEF00D;
    tick;
    tick;
    Reset = 1'b0;
    mfa = 1'b0;
    #1;
    chk("rst_mid_wait_mfc", {31'h0, mfc}, 32'h0);
    chk("rst_mid_wait_dout", dout, 32'h0);
    #10 Reset = 1'b1;
    tick;
    xact(0, RW_READ, SZ_WORD, 32'h10, 32'h0, 3, 1'b0);
    chk("aborted_write_not_committed", dout, 32'hDEADBEEF);
    xact(0, RW_WRITE, SZ_BYTE, 32'h11, 32'hFFFFFF5A, 3, 1'b0);
    chk("byte_write_keeps_dout", dout, 32'hDEADBEEF);
    xact(0, RW_READ, SZ_WORD, 32'h10, 32'h0, 3, 1'b0);
    chk("merged_word", dout, 32'hDEAD5AEF);
    mfa = 1'b1; rw = RW_READ; wb = SZ_BYTE; addr = 32'h13;
    tick;
    chk("drop_e0_mfc", {31'h0, mfc}, 32'h0);
    tick;
    mfa = 1'b0;
    tick;
    chk("drop_e2_mfc", {31'h0, mfc}, 32'h0);
    tick;
    chk("drop_e3_mfc", {31'h0, mfc}, 32'h1);
    chk("drop_e3_dout", dout, 32'h000000DE);
    tick;
    chk("drop_e4_mfc", {31'h0, mfc}, 32'h0);
    chk("drop_e4_dout", dout, 32'h000000DE);
`ifdef MEM_ALIGN_FAULT_EN
    xact(0, RW_WRITE, SZ_WORD, 32'h13, 32'h12345678, 3, 1'b1);
    xact(0, RW_READ, SZ_WORD, 32'h10, 32'h0, 3, 1'b0);
    chk("misaligned_write_suppressed", dout, 32'hDEAD5AEF);
    xact(0, RW_READ, SZ_WORD, 32'h11, 32'h0, 3, 1'b1);
    chk("misaligned_read_keeps_dout", dout, 32'hDEAD5AEF);
`else
    xact(0, RW_WRITE, SZ_WORD, 32'h13, 32'h12345678, 3, 1'b0);
    xact(0, RW_READ, SZ_WORD, 32'h10, 32'h0, 3, 1'b0);
    chk("misaligned_write_aligned", dout, 32'h12345678);
`endif
    xact(1, RW_WRITE, SZ_WORD, 32'h4, 32'hA5A50F0F, 1, 1'b0);
    xact(1, RW_READ, SZ_WORD, 32'h204, 32'h0, 1, 1'b0);
    chk("wrap_word_read", dout0, 32'hA5A50F0F);
    xact(1, RW_READ, SZ_BYTE, 32'hFFFFFE07, 32'h0, 1, 1'b0);
    chk("high_bits_ignored", dout0, 32'h000000A5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
